fxp_square_iter: RTL
====================

// Module: fxp_square_iter
// PURPOSE
//  Inverse of the CORDIC square-root pipeline: takes an unsigned fixed-point root
//  (WIDTH bits, OUT_F_WIDTH fraction bits, same format as the sqrt output) and returns
//  round(root^2) as an unsigned WIDTH-bit integer.
//  Built as an iterative shift-add multiplier FSM with a valid/ready handshake on both sides.
//  Used as the in-system checker/decoder behind the sqrt block. Cheap in area, not pipelined.
// PARAMETERS
//  WIDTH        16  data width of root input and integer output
//  OUT_F_WIDTH   6  fraction bits of the root input; must be <= WIDTH/2
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            asynchronous, active-high reset
//  root       in   WIDTH        unsigned root, fixed point with OUT_F_WIDTH fraction bits
//  in_valid   in   1            root is valid
//  in_ready   out  1            block can accept; high only in IDLE
//  N          out  WIDTH        round(root^2), saturated to 2^WIDTH-1
//  ovf        out  1            saturation occurred (qualified by out_valid)
//  out_valid  out  1            N/ovf valid
//  out_ready  in   1            consumer accepts the result
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; N=0, ovf=0, out_valid=0, in_ready=1; accumulator and counter cleared.
//  States:
//  - IDLE:  in_ready=1. On in_valid&in_ready (edge E0): latch root as multiplicand and multiplier; acc=0; cnt=0; go to MUL.
//  - MUL:   one bit per edge, LSB first: if mplr[0], acc+=mcand; mcand<<=1; mplr>>=1; cnt++.
//           acc and mcand are 2*WIDTH bits. After WIDTH edges (E1..E_WIDTH), go to ROUND.
//  - ROUND: t = acc + 2^(2*OUT_F_WIDTH-1); q = t >> (2*OUT_F_WIDTH) (round half-up).
//           If q >= 2^WIDTH: N=all ones, ovf=1; else N=q[WIDTH-1:0], ovf=0.
//           Register N/ovf; out_valid=1; go to DONE (edge E_WIDTH+1).
//  - DONE:  hold N, ovf and out_valid stable. On out_valid&out_ready: out_valid=0; go to IDLE.
//           in_ready rises on the following cycle; no same-cycle pass-through.
//  Latency: out_valid rises WIDTH+1 edges after the accepting edge (17 for defaults).
//           Minimum issue interval is WIDTH+3 cycles.
//  in_valid outside IDLE is ignored and does not affect the transaction in flight.
//  root is sampled only at E0; later changes have no effect.
//  root=0 gives N=0, ovf=0 with the normal latency; there is no early exit.
//  Exact ties (fraction = .5) cannot occur for a squared input; the rounding rule is still half-up.
//  rst asserted during MUL, ROUND or DONE aborts: outputs return to reset values immediately.
//  The aborted result is never presented.
//  Handshake signals are never combinationally dependent on in_valid or out_ready.
// STRUCTURE
//  Shared header: WIDTH/OUT_F_WIDTH defaults (same values as the sqrt block) and the
//  state encodings IDLE=2'd0, MUL=2'd1, ROUND=2'd2, DONE=2'd3.
//  One sub-module: fxp_round_sat, a combinational round-half-up, shift and saturate
//  stage (2*WIDTH in -> WIDTH out + ovf). It is instantiated in ROUND and reusable by the sqrt path.
//  Everything else (FSM, counter, shift-add datapath) lives in this module.
// TESTING
//  1. root=16'h0280 (10.0) -> N=100, ovf=0; out_valid exactly 17 edges after accept.
//  2. root=16'h3FFF (255.984375) -> N=65528, ovf=0.
//  3. root=16'h008F (2.234375, sq 4.99) -> N=5; root=16'h0062 (sq 2.34) -> N=2; root=0 -> N=0.
//  4. root=16'h4000 (256.0) -> N=16'hFFFF, ovf=1; root=16'hFFFF -> N=16'hFFFF, ovf=1.
//  5. Backpressure: hold out_ready=0 for 5 cycles after out_valid.
//     -> N/ovf/out_valid stable, in_ready=0, and an in_valid pulse is ignored.
//     Release out_ready -> in_ready=1 the next cycle.
//  6. Assert rst at edge E8 of a transaction.
//     -> out_valid=0 and in_ready=1 immediately; no stale result appears.
//     A new op with root=16'h0040 then yields N=1 after 17 edges.
//  Reference model: round(root^2/2^12) saturated; random 10k roots with random out_ready stalls.

Source files
------------

// File: rtl/fxp_square_iter_pkg.sv
// Shared defaults and FSM state encoding for the fixed-point square iterator.
// The width defaults match the sqrt block that feeds this checker.
package fxp_square_iter_pkg;

    localparam int unsigned DEF_WIDTH       = 16;
    localparam int unsigned DEF_OUT_F_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fxp_square_iter_if.sv
// Valid/ready bus for the square iterator: root in, rounded integer square out.
interface fxp_square_iter_if
    import fxp_square_iter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic [WIDTH-1:0] root;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] N;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output root, in_valid, out_ready,
        input  in_ready, N, ovf, out_valid
    );

    modport slave (
        input  root, in_valid, out_ready,
        output in_ready, N, ovf, out_valid
    );

endinterface

// File: rtl/fxp_round_sat.sv
// Combinational round-half-up, right shift by SHIFT and saturate to OUT_WIDTH bits.
// SHIFT must be at least 1.
module fxp_round_sat
    import fxp_square_iter_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 2 * DEF_WIDTH,
    parameter int unsigned OUT_WIDTH = DEF_WIDTH,
    parameter int unsigned SHIFT     = 2 * DEF_OUT_F_WIDTH
) (
    input  logic [IN_WIDTH-1:0]  din,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 ovf
);

    localparam logic [IN_WIDTH:0] HALF = (IN_WIDTH + 1)'(1) << (SHIFT - 1);

    // One extra bit so the rounding add cannot wrap on an all-ones input.
    logic [IN_WIDTH:0] sum;
    logic [IN_WIDTH:0] q;

    always_comb begin
        sum  = {1'b0, din} + HALF;
        q    = sum >> SHIFT;
        ovf  = |q[IN_WIDTH:OUT_WIDTH];
        dout = ovf ? '1 : q[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/fxp_square_iter.sv
// Iterative shift-add squarer: returns round(root^2) of an unsigned fixed-point root,
// one multiplier bit per cycle, with valid/ready handshakes on both sides.
module fxp_square_iter
    import fxp_square_iter_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned OUT_F_WIDTH = DEF_OUT_F_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    fxp_square_iter_if.slave  bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     n_q, n_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;

    logic [WIDTH-1:0]     rs_n;
    logic                 rs_ovf;

    fxp_round_sat #(
        .IN_WIDTH  (2 * WIDTH),
        .OUT_WIDTH (WIDTH),
        .SHIFT     (2 * OUT_F_WIDTH)
    ) u_round_sat (
        .din  (acc_q),
        .dout (rs_n),
        .ovf  (rs_ovf)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplr_d      = mplr_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    mcand_d              = '0;
                    mcand_d[WIDTH-1:0]   = bus.root;
                    mplr_d               = bus.root;
                    acc_d                = '0;
                    cnt_d                = '0;
                    state_d              = MUL;
                end
            end
            MUL: begin
                if (mplr_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                n_d         = rs_n;
                ovf_d       = rs_ovf;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered, so ready only reappears the cycle after the result handshake.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplr_q      <= mplr_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.N         = n_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;

endmodule
